// File: rtl/nonce_dispatch_pkg.sv
// nonce_dispatch_pkg: shared widths and tx FSM encodings for the nonce dispatcher
package nonce_dispatch_pkg;
    localparam int NONCE_W = 32;
    localparam int DROP_W = 8;
    typedef enum logic [3:0] {
        ST_IDLE      = 4'b0001,
        ST_SEND      = 4'b0010,
        ST_WAIT_BUSY = 4'b0100,
        ST_WAIT_DONE = 4'b1000
    } state_t;
endpackage

// File: rtl/nonce_fifo.sv
// nonce_fifo: synchronous first-word-fall-through FIFO with occupancy count
module nonce_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;

    assign empty = count == '0;
    assign full = count == (AW+1)'(DEPTH);
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout = mem[rd_ptr];

    // storage array carries no reset; only pointers and count define validity
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/nonce_dispatch.sv
// nonce_dispatch: captures worker nonces, round-robins them into a FIFO and paces the serial transmitter
module nonce_dispatch
    import nonce_dispatch_pkg::*;
#(
    parameter int SLAVES = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SLAVES-1:0]             new_nonces,
    input  logic [SLAVES*NONCE_W-1:0]     slave_nonces,
    input  logic                          serial_busy,
    output logic                          serial_send,
    output logic [NONCE_W-1:0]            golden_nonce,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [DROP_W-1:0]             drop_count,
    output logic                          overflow
);
    localparam int IDX_W = (SLAVES > 1) ? $clog2(SLAVES) : 1;
    localparam int TO_W = $clog2(BUSY_TIMEOUT) + 1;

    logic [SLAVES-1:0] pending, gvec, drop;
    logic [NONCE_W-1:0] hold [SLAVES];
    logic [IDX_W-1:0] ptr, gidx, cand;
    logic grant, fifo_full, fifo_empty, pop;
    logic [NONCE_W-1:0] fifo_dout;
    logic [DROP_W:0] drop_sum;
    logic [TO_W-1:0] to_cnt;
    state_t state, state_nxt;

    // round-robin search for the first pending slave at or after ptr
    always_comb begin
        grant = 1'b0;
        gidx = '0;
        cand = '0;
        gvec = '0;
        for (int k = 0; k < SLAVES; k++) begin
            cand = IDX_W'((int'(ptr) + k) % SLAVES);
            if (!grant && pending[cand] && !fifo_full) begin
                grant = 1'b1;
                gidx = cand;
            end
        end
        if (grant) gvec[gidx] = 1'b1;
    end

    // a new pulse is dropped only when its slave is still pending and not being drained this cycle
    always_comb begin
        drop = new_nonces & pending & ~gvec;
        drop_sum = {1'b0, drop_count};
        for (int i = 0; i < SLAVES; i++) drop_sum = drop_sum + (DROP_W+1)'(drop[i]);
    end

    // holding registers load on any accepted pulse, including a same-cycle regrant
    always_ff @(posedge clk) begin
        for (int i = 0; i < SLAVES; i++)
            if (new_nonces[i] && !drop[i]) hold[i] <= slave_nonces[NONCE_W*i +: NONCE_W];
    end

    // pending flags, round-robin pointer and drop statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            ptr <= '0;
            drop_count <= '0;
            overflow <= 1'b0;
        end else begin
            pending <= new_nonces | (pending & ~gvec);
            if (grant) ptr <= (int'(gidx) == SLAVES - 1) ? '0 : gidx + 1'b1;
            drop_count <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
            overflow <= overflow | (|drop);
        end
    end

    nonce_fifo #(.WIDTH(NONCE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(grant),
        .din(hold[gidx]),
        .pop(pop),
        .dout(fifo_dout),
        .empty(fifo_empty),
        .full(fifo_full),
        .count(fifo_count)
    );

    // tx sequencing: pop in IDLE, strobe in SEND, then wait for the serial core to finish
    always_comb begin
        state_nxt = state;
        pop = 1'b0;
        serial_send = 1'b0;
        case (state)
            ST_IDLE: if (!fifo_empty && !serial_busy) begin
                pop = 1'b1;
                state_nxt = ST_SEND;
            end
            ST_SEND: begin
                serial_send = 1'b1;
                state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: state_nxt = serial_busy ? ST_WAIT_DONE :
                                      (to_cnt == TO_W'(BUSY_TIMEOUT - 1)) ? ST_IDLE : ST_WAIT_BUSY;
            ST_WAIT_DONE: state_nxt = serial_busy ? ST_WAIT_DONE : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // state, busy timeout counter (runs only in WAIT_BUSY) and the transmitted word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            to_cnt <= '0;
            golden_nonce <= '0;
        end else begin
            state <= state_nxt;
            to_cnt <= (state == ST_WAIT_BUSY) ? to_cnt + 1'b1 : '0;
            if (pop) golden_nonce <= fifo_dout;
        end
    end
endmodule
